// File: rtl/argmax_classifier_if.sv
// Stream bundle for the argmax classifier: activation beats in, classification result out.
// The slave side belongs to the classifier, the master side to whatever feeds and drains it.
interface argmax_classifier_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_class;
  logic [DATA_W-1:0] out_score;
  logic              out_error;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_class, out_score, out_error
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_class, out_score, out_error
  );
endinterface

// File: rtl/argmax_classifier.sv
// Running-maximum classifier over a serial frame of unsigned activations.
// Presents the winning class index, its score and a frame-length error flag.
module argmax_classifier #(
  parameter int CLASS_COUNT = 10,
  parameter int DATA_W      = 8,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  argmax_classifier_if.slave bus
);

  typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLASS_COUNT - 1);

  state_t            state_r;
  state_t            state_s;
  logic [IDX_W-1:0]  cnt_r;
  logic [DATA_W-1:0] max_r;
  logic [IDX_W-1:0]  idx_r;
  logic              out_valid_r;
  logic [IDX_W-1:0]  out_class_r;
  logic [DATA_W-1:0] out_score_r;
  logic              out_error_r;

  logic              beat_s;
  logic              take_s;
  logic              final_s;
  logic              err_s;
  logic              done_s;
  logic [DATA_W-1:0] max_s;
  logic [IDX_W-1:0]  idx_s;

  assign bus.in_ready  = (state_r == ACC) && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.out_class = out_class_r;
  assign bus.out_score = out_score_r;
  assign bus.out_error = out_error_r;

  // Beat acceptance, candidate maximum and next-state decode
  always_comb begin
    beat_s  = 1'b0;
    take_s  = 1'b0;
    final_s = 1'b0;
    err_s   = 1'b0;
    done_s  = 1'b0;
    max_s   = max_r;
    idx_s   = idx_r;
    state_s = state_r;

    beat_s = bus.in_valid && (state_r == ACC);
    // First beat always seeds the maximum; later beats need a strict win so ties keep the lower index
    take_s = (cnt_r == {IDX_W{1'b0}}) || (bus.in_data > max_r);
    if (take_s) begin
      max_s = bus.in_data;
      idx_s = cnt_r;
    end else begin
      max_s = max_r;
      idx_s = idx_r;
    end
    final_s = beat_s && (bus.in_last || (cnt_r == LAST_IDX));
    err_s   = bus.in_last ^ (cnt_r == LAST_IDX);
    done_s  = (state_r == OUT) && out_valid_r && bus.out_ready;

    case (state_r)
      ACC: begin
        if (final_s) state_s = OUT;
        else         state_s = ACC;
      end
      OUT: begin
        if (done_s) state_s = ACC;
        else        state_s = OUT;
      end
      default: state_s = ACC;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ACC;
    else     state_r <= state_s;
  end

  // Frame accumulator and held result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= {IDX_W{1'b0}};
      max_r       <= {DATA_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      out_valid_r <= 1'b0;
      out_class_r <= {IDX_W{1'b0}};
      out_score_r <= {DATA_W{1'b0}};
      out_error_r <= 1'b0;
    end else if (done_s) begin
      cnt_r       <= {IDX_W{1'b0}};
      max_r       <= {DATA_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (final_s) begin
      out_valid_r <= 1'b1;
      out_class_r <= idx_s;
      out_score_r <= max_s;
      out_error_r <= err_s;
    end else if (beat_s) begin
      cnt_r <= cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
      max_r <= max_s;
      idx_r <= idx_s;
    end else begin
      cnt_r <= cnt_r;
      max_r <= max_r;
      idx_r <= idx_r;
    end
  end

endmodule
